// File: rtl/int_gen.sv
// int_gen: memory-mapped periodic interrupt generator acknowledged by a CPU write
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset
//   addr      - byte address (m_int_addr); block answers BASE..BASE+0xF
//   byteen    - write byte enables (m_int_byteen); 0 means no write
//   wdata     - write data (m_data_wdata)
//   rdata     - combinational read data, 0 outside the window
//   interrupt - registered level interrupt request
//
// Register map: 0x0 ACK (wo), 0x4 PERIOD (rw), 0x8 CTRL {RELOAD, EN}, 0xC COUNT (ro)
// Macro INT_GEN_AUTORELOAD_EN: when defined, CTRL.RELOAD is stored and an ACK
// re-arms the count; otherwise every ACK ends in IDLE (one-shot).
module int_gen #(
   parameter logic [31:0] RESET_PERIOD = 32'd0,
   parameter logic [31:0] BASE         = 32'h0000_7F20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        interrupt
);
   typedef enum logic [1:0] {IDLE, COUNT, PEND} state_t;
   state_t state_q, state_d;
   logic [31:0] period_q, period_d, count_q, count_d;
   logic en_q, en_d, irq_q, reload;
   logic sel, wr, wr_ack, wr_period, wr_ctrl, en_w;
   logic [1:0] unused_addr;
   assign unused_addr = addr[1:0];
   assign sel       = addr[31:4] == BASE[31:4];
   assign wr        = sel && (byteen != 4'd0);
   assign wr_ack    = wr && (addr[3:2] == 2'd0);
   assign wr_period = wr && (addr[3:2] == 2'd1);
   assign wr_ctrl   = wr && (addr[3:2] == 2'd2);
   // EN as it would read after a byte-merged CTRL write
   assign en_w      = byteen[0] ? wdata[0] : en_q;
`ifdef INT_GEN_AUTORELOAD_EN
   logic reload_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) reload_q <= 1'b0;
      else if (wr_ctrl && byteen[0]) reload_q <= wdata[1];
   assign reload = reload_q;
`else
   assign reload = 1'b0;
`endif
   always_comb begin
      period_d = period_q;
      if (wr_period)
         for (int i = 0; i < 4; i++)
            if (byteen[i]) period_d[8*i +: 8] = wdata[8*i +: 8];
   end
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      en_d    = wr_ctrl ? en_w : en_q;
      case (state_q)
         IDLE:
            if (wr_ctrl && en_w) begin
               state_d = COUNT;
               count_d = period_q;
            end
         COUNT:
            if (wr_ctrl && !en_w) state_d = IDLE;
            else if (count_q == 32'd0) state_d = PEND;
            else count_d = count_q - 32'd1;
         PEND:
            if (wr_ctrl && !en_w) state_d = IDLE;
            else if (wr_ack && reload) begin
               state_d = COUNT;
               count_d = period_q;
            end else if (wr_ack) begin
               state_d = IDLE;
               en_d    = 1'b0;
            end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q  <= IDLE;
         period_q <= RESET_PERIOD;
         count_q  <= 32'd0;
         en_q     <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         count_q  <= count_d;
         en_q     <= en_d;
         irq_q    <= state_d == PEND;
      end
   assign interrupt = irq_q;
   always_comb
      rdata = !sel               ? 32'd0 :
              addr[3:2] == 2'd1 ? period_q :
              addr[3:2] == 2'd2 ? {30'd0, reload, en_q} :
              addr[3:2] == 2'd3 ? count_q : 32'd0;
endmodule

// File: tb/tb_int_gen.sv
// tb_int_gen: directed self-checking bench for int_gen
module tb_int_gen;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  byteen;
   logic        interrupt;
   int n_chk = 0, n_pass = 0, n_fail = 0;
   localparam logic [31:0] A_ACK = 32'h7F20, A_PER = 32'h7F24, A_CTRL = 32'h7F28, A_CNT = 32'h7F2C;

   int_gen dut (
      .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
      .wdata(wdata), .rdata(rdata), .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      byteen = 4'd0;
      #1;
      chk(tag, rdata, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a;
      byteen = be;
      wdata = d;
      tick();
      byteen = 4'd0;
      addr = 32'd0;
   endtask

   initial begin
      reset = 1'b0;
      addr = 32'd0;
      byteen = 4'd0;
      wdata = 32'd0;
      #12;
      chk("irq_in_reset", interrupt, 0);
      reset = 1'b1;
      tick();
      // reset values
      chk_rd("rst_period", A_PER, 32'd0);
      chk_rd("rst_ctrl", A_CTRL, 32'd0);
      chk_rd("rst_count", A_CNT, 32'd0);
      chk_rd("rst_ack", A_ACK, 32'd0);
      chk_rd("outside", 32'h7F30, 32'd0);
      chk("rst_irq", interrupt, 0);
      // one-shot, PERIOD=5
      wr(A_PER, 4'hF, 32'd5);
      chk_rd("period5", A_PER, 32'd5);
      wr(A_CTRL, 4'hF, 32'd1);
      chk_rd("cnt5", A_CNT, 32'd5);
      chk_rd("ctrl_en", A_CTRL, 32'd1);
      chk("irq_c5", interrupt, 0);
      for (int i = 4; i >= 0; i--) begin
         tick();
         chk_rd("cnt_down", A_CNT, i);
         chk("irq_counting", interrupt, 0);
      end
      tick();
      chk("irq_rise6", interrupt, 1);
      tick();
      chk("irq_hold", interrupt, 1);
      wr(A_ACK, 4'hF, 32'd0);
      chk("irq_ack", interrupt, 0);
      chk_rd("ctrl_after_ack", A_CTRL, 32'd0);
      // reload
      wr(A_PER, 4'hF, 32'd3);
      wr(A_CTRL, 4'hF, 32'd3);
`ifdef INT_GEN_AUTORELOAD_EN
      chk_rd("ctrl_reload", A_CTRL, 32'd3);
`else
      chk_rd("ctrl_noreload", A_CTRL, 32'd1);
`endif
      repeat (3) tick();
      chk("rl_irq_e3", interrupt, 0);
      tick();
      chk("rl_irq_e4", interrupt, 1);
      wr(A_ACK, 4'hF, 32'd0);
      chk("rl_ack1", interrupt, 0);
`ifdef INT_GEN_AUTORELOAD_EN
      chk_rd("rl_cnt3", A_CNT, 32'd3);
      repeat (3) tick();
      chk("rl2_irq_a3", interrupt, 0);
      tick();
      chk("rl2_irq_a4", interrupt, 1);
      wr(A_ACK, 4'hF, 32'd0);
      chk("rl_ack2", interrupt, 0);
      wr(A_CTRL, 4'hF, 32'd0);
      chk_rd("rl_cnt_frozen", A_CNT, 32'd3);
`else
      chk_rd("os_ctrl", A_CTRL, 32'd0);
      repeat (6) tick();
      chk("os_no_repeat", interrupt, 0);
`endif
      // byte-lane PERIOD write during COUNT keeps running schedule
      wr(A_PER, 4'hF, 32'd10);
      wr(A_CTRL, 4'hF, 32'd1);
      tick();
      wr(A_PER, 4'b0001, 32'hFFFF_FFAB);
      chk_rd("period_byte", A_PER, 32'h0000_00AB);
      chk_rd("cnt_unchanged", A_CNT, 32'd8);
      repeat (8) tick();
      chk("old_sched_e10", interrupt, 0);
      tick();
      chk("old_sched_e11", interrupt, 1);
      wr(A_ACK, 4'hF, 32'd0);
      chk("ack_again", interrupt, 0);
      // ACK ignored in COUNT, then disable freezes COUNT
      wr(A_PER, 4'hF, 32'd20);
      wr(A_CTRL, 4'hF, 32'd1);
      tick();
      wr(A_ACK, 4'hF, 32'd0);
      chk_rd("ack_ignored", A_CNT, 32'd18);
      wr(A_CTRL, 4'hF, 32'd0);
      chk_rd("frozen_cnt", A_CNT, 32'd18);
      chk_rd("disabled_ctrl", A_CTRL, 32'd0);
      repeat (30) tick();
      chk_rd("still_frozen", A_CNT, 32'd18);
      chk("idle_irq", interrupt, 0);
      // PERIOD=0: PEND one cycle after arming
      wr(A_PER, 4'hF, 32'd0);
      wr(A_CTRL, 4'hF, 32'd1);
      chk("p0_irq_e0", interrupt, 0);
      tick();
      chk("p0_irq_e1", interrupt, 1);
      // asynchronous reset while in PEND
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_irq", interrupt, 0);
      chk_rd("async_rst_cnt", A_CNT, 32'd0);
      chk_rd("async_rst_ctrl", A_CTRL, 32'd0);
      #1;
      reset = 1'b1;
      repeat (4) tick();
      chk("post_rst_idle", interrupt, 0);
      wr(A_PER, 4'hF, 32'd2);
      wr(A_CTRL, 4'hF, 32'd1);
      repeat (2) tick();
      chk("rearm_e2", interrupt, 0);
      tick();
      chk("rearm_e3", interrupt, 1);
      wr(A_ACK, 4'hF, 32'd0);
      chk("rearm_ack", interrupt, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
